// File: rtl/div_top_if.sv
// div_top_if: start/done handshake, operands and results of the signed divider.
interface div_top_if #(parameter int K = 4);
  logic           start;
  logic [2*K-1:0] z;
  logic [K-1:0]   d;
  logic [K-1:0]   q;
  logic [K-1:0]   s;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic           overflow;
  modport master (output start, z, d, input q, s, busy, done, div_by_zero, overflow);
  modport slave  (input start, z, d, output q, s, busy, done, div_by_zero, overflow);
endinterface

// File: rtl/div_top.sv
// div_top: sequential signed 2K/K divider, restoring shift-subtract on magnitudes plus a sign fix.
module div_top #(parameter int K = 4) (
  input logic clk,
  input logic rst_n,
  div_top_if.slave io
);
  localparam int CW = $clog2(K + 1);
  localparam logic [K-1:0] HALF = K'(1) << (K - 1);
  localparam logic [K-1:0] MAXP = HALF - K'(1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [K-1:0] r_q, r_d, qm_q, qm_d, dm_q, dm_d, q_q, q_d, s_q, s_d;
  logic sq_q, sq_d, ss_q, ss_d, dz_q, dz_d, ov_q, ov_d;
  logic [2*K-1:0] za;
  logic [K-1:0] da;
  logic [K:0] rs;
  logic ge, fix_ov;
  always_comb begin
    za = io.z[2*K-1] ? -io.z : io.z;
    da = io.d[K-1] ? -io.d : io.d;
    rs = {r_q, qm_q[K-1]};
    ge = rs >= {1'b0, dm_q};
    fix_ov = sq_q ? qm_q > HALF : qm_q > MAXP;
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    qm_d = qm_q;
    dm_d = dm_q;
    q_d = q_q;
    s_d = s_q;
    sq_d = sq_q;
    ss_d = ss_q;
    dz_d = dz_q;
    ov_d = ov_q;
    case (state_q)
      IDLE: if (io.start) begin
        sq_d = io.z[2*K-1] ^ io.d[K-1];
        ss_d = io.z[2*K-1];
        dm_d = da;
        r_d = za[2*K-1:K];
        qm_d = za[K-1:0];
        cnt_d = CW'(K);
        dz_d = io.d == '0;
        // a high half already >= |d| means the quotient needs more than K bits
        ov_d = !dz_d && za[2*K-1:K] >= da;
        state_d = (dz_d || ov_d) ? DONE : RUN;
        q_d = (dz_d || ov_d) ? '0 : q_q;
        s_d = (dz_d || ov_d) ? '0 : s_q;
      end
      RUN: begin
        r_d = ge ? K'(rs - {1'b0, dm_q}) : rs[K-1:0];
        qm_d = {qm_q[K-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? FIX : RUN;
      end
      FIX: begin
        ov_d = fix_ov;
        q_d = fix_ov ? '0 : sq_q ? -qm_q : qm_q;
        s_d = fix_ov ? '0 : ss_q ? -r_q : r_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      r_q <= '0;
      qm_q <= '0;
      dm_q <= '0;
      q_q <= '0;
      s_q <= '0;
      sq_q <= 1'b0;
      ss_q <= 1'b0;
      dz_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      qm_q <= qm_d;
      dm_q <= dm_d;
      q_q <= q_d;
      s_q <= s_d;
      sq_q <= sq_d;
      ss_q <= ss_d;
      dz_q <= dz_d;
      ov_q <= ov_d;
    end
  end
  assign io.q = q_q;
  assign io.s = s_q;
  assign io.busy = state_q != IDLE;
  assign io.done = state_q == DONE;
  assign io.div_by_zero = dz_q;
  assign io.overflow = ov_q;
endmodule
